// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the RV32I data-memory load/store unit.
// Holds the FSM state, funct3 codes, the latched request and byte-enable generation.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Store byte lanes; funct3[1:0] carries the access size for both signed and unsigned codes.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core request/response handshake plus the word-wide RAM port of the load/store unit.
// master = core and RAM side, slave = the load/store unit.
interface dmem_lsu_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data from a RAM word,
// and replicates store data across all lanes so the byte enables alone pick the target.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] raw_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = raw_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    load_data_o  = raw_i;
    store_data_o = raw_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = raw_i;
    endcase
    case (funct3_i[1:0])
      2'b00:   store_data_o = {4{raw_i[7:0]}};
      2'b01:   store_data_o = {2{raw_i[15:0]}};
      default: store_data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit: latches one core request, checks it, drives a single RAM
// access and returns an extended, registered response with a valid/ready handshake.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  dmem_lsu_if.slave bus
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

  lsu_state_t  state_q;
  lsu_req_t    req_q;
  logic [1:0]  cnt_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        bad_f3, misaligned, out_of_range, req_err, mem_go;
  logic [31:0] raw_word, load_data, store_data;

  assign bad_f3 = req_q.we ? !(req_q.funct3 inside {F3_B, F3_H, F3_W})
                           :  (req_q.funct3 inside {3'b011, 3'b110, 3'b111});
  assign misaligned   = ((req_q.funct3[1:0] == 2'b01) && req_q.addr[0]) ||
                        ((req_q.funct3[1:0] == 2'b10) && (req_q.addr[1:0] != 2'b00));
  assign out_of_range = |req_q.addr[31:AW+2];
  assign req_err      = bad_f3 || misaligned || out_of_range;

  assign raw_word = req_q.we ? req_q.wdata : bus.mem_rdata;

  lsu_align u_align (
    .funct3_i     (req_q.funct3),
    .addr_lo_i    (req_q.addr[1:0]),
    .raw_i        (raw_word),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  // Reset gates the strobe directly so a reset landing in ISSUE can never write RAM.
  assign mem_go        = (state_q == ISSUE) && !req_err && !reset;
  assign bus.mem_en    = mem_go;
  assign bus.mem_we    = mem_go && req_q.we;
  assign bus.mem_be    = !mem_go  ? 4'b0000 :
                         req_q.we ? be_gen(req_q.funct3, req_q.addr[1:0]) : 4'b1111;
  assign bus.mem_addr  = req_q.addr[AW+1:2];
  assign bus.mem_wdata = store_data;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the request payload is reset too, keeping mem_addr/mem_wdata defined out of reset.
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          req_q   <= '{we: bus.req_we, funct3: bus.req_funct3,
                       addr: bus.req_addr, wdata: bus.req_wdata};
          state_q <= ISSUE;
        end
        ISSUE: begin
          if (req_err || req_q.we) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q   <= LAT_M1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_data;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural RAM of configurable read latency.
module tb_dmem_lsu;
  import lsu_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_lsu_if #(.AW(AW)) bus ();

  dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural RAM: byte-enabled write at the mem_en edge, read data LAT cycles after mem_en.
  logic [31:0] ram  [DEPTH] = '{default: '0};
  logic [31:0] pipe [LAT]   = '{default: '0};

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Per-transaction observations, filled by run_txn and compared in the main sequence.
  int          t_ready, t_en_cnt, t_en_cyc, t_rsp_cyc, t_unstable;
  int          be_leak = 0;
  logic [3:0]  t_be;
  logic        t_we, t_err;
  logic [AW-1:0] t_addr;
  logic [31:0] t_wdata, t_rdata;

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    t_ready        = int'(bus.req_ready);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = ~wdata;
    t_en_cnt = 0; t_en_cyc = -1; t_rsp_cyc = -1; t_unstable = 0;
    t_be = 'x; t_we = 'x; t_addr = 'x; t_wdata = 'x; t_rdata = 'x; t_err = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        t_en_cnt++;
        t_en_cyc = k;
        t_be     = bus.mem_be;
        t_we     = bus.mem_we;
        t_addr   = bus.mem_addr;
        t_wdata  = bus.mem_wdata;
      end else if (bus.mem_be !== 4'b0000) begin
        be_leak++;
      end
      if (bus.rsp_valid === 1'b1) begin
        t_rsp_cyc = k;
        t_rdata   = bus.rsp_rdata;
        t_err     = bus.rsp_err;
        break;
      end
    end
    if (t_rsp_cyc > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== t_rdata || bus.rsp_err !== t_err)
          t_unstable++;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int stale;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err",   bus.rsp_err,   0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_en",    bus.mem_en,    0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_be",    bus.mem_be,    0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.req_ready, 1);

    // T1: sw then lw of a full word.
    run_txn(1'b1, F3_W, 32'h64, 32'hDEAD_BEEF, 0);
    check("t1_sw_accept",  t_ready,   1);
    check("t1_sw_en_cnt",  t_en_cnt,  1);
    check("t1_sw_en_cyc",  t_en_cyc,  1);
    check("t1_sw_be",      t_be,      4'b1111);
    check("t1_sw_we",      t_we,      1);
    check("t1_sw_addr",    t_addr,    8'h19);
    check("t1_sw_wdata",   t_wdata,   32'hDEAD_BEEF);
    check("t1_sw_rsp_cyc", t_rsp_cyc, 2);
    check("t1_sw_err",     t_err,     0);
    check("t1_sw_rdata",   t_rdata,   0);
    check("t1_ram",        ram[8'h19], 32'hDEAD_BEEF);
    run_txn(1'b0, F3_W, 32'h64, 32'h0, 0);
    check("t1_lw_en_cyc",  t_en_cyc,  1);
    check("t1_lw_be",      t_be,      4'b1111);
    check("t1_lw_we",      t_we,      0);
    check("t1_lw_rsp_cyc", t_rsp_cyc, 2 + LAT);
    check("t1_lw_rdata",   t_rdata,   32'hDEAD_BEEF);
    check("t1_lw_err",     t_err,     0);

    // T2: sb into lane 1, then signed and unsigned byte loads.
    run_txn(1'b1, F3_B, 32'h61, 32'h1234_5680, 0);
    check("t2_sb_be",    t_be,    4'b0010);
    check("t2_sb_wdata", t_wdata, 32'h8080_8080);
    check("t2_ram",      ram[8'h18], 32'h0000_8000);
    run_txn(1'b0, F3_B, 32'h61, 32'h0, 0);
    check("t2_lb",  t_rdata, 32'hFFFF_FF80);
    run_txn(1'b0, F3_BU, 32'h61, 32'h0, 0);
    check("t2_lbu", t_rdata, 32'h0000_0080);

    // T3: sh into the upper half, then half loads and lane-3/lane-0 boundaries.
    run_txn(1'b1, F3_H, 32'h62, 32'hABCD_8001, 0);
    check("t3_sh_be",    t_be,    4'b1100);
    check("t3_sh_wdata", t_wdata, 32'h8001_8001);
    check("t3_ram",      ram[8'h18], 32'h8001_8000);
    run_txn(1'b0, F3_H, 32'h62, 32'h0, 0);
    check("t3_lh",  t_rdata, 32'hFFFF_8001);
    run_txn(1'b0, F3_HU, 32'h62, 32'h0, 0);
    check("t3_lhu", t_rdata, 32'h0000_8001);
    run_txn(1'b0, F3_BU, 32'h63, 32'h0, 0);
    check("t3_lbu_lane3", t_rdata, 32'h0000_0080);
    run_txn(1'b0, F3_H, 32'h60, 32'h0, 0);
    check("t3_lh_low",    t_rdata, 32'hFFFF_8000);

    // T4: misaligned accesses fault without touching RAM.
    run_txn(1'b0, F3_W, 32'h66, 32'h0, 0);
    check("t4_lw_err",     t_err,     1);
    check("t4_lw_rsp_cyc", t_rsp_cyc, 2);
    check("t4_lw_en_cnt",  t_en_cnt,  0);
    check("t4_lw_rdata",   t_rdata,   0);
    run_txn(1'b1, F3_H, 32'h63, 32'h0000_AAAA, 0);
    check("t4_sh_err",     t_err,     1);
    check("t4_sh_en_cnt",  t_en_cnt,  0);
    check("t4_ram",        ram[8'h18], 32'h8001_8000);

    // T5: out-of-range and illegal funct3.
    run_txn(1'b0, F3_W, 32'h400, 32'h0, 0);
    check("t5_oor_err",    t_err,    1);
    check("t5_oor_rdata",  t_rdata,  0);
    check("t5_oor_en_cnt", t_en_cnt, 0);
    run_txn(1'b0, 3'b011, 32'h64, 32'h0, 0);
    check("t5_f3_err",     t_err,    1);
    check("t5_f3_rdata",   t_rdata,  0);
    run_txn(1'b1, F3_BU, 32'h64, 32'h5555_5555, 0);
    check("t5_sf3_err",    t_err,    1);
    check("t5_sf3_ram",    ram[8'h19], 32'hDEAD_BEEF);

    // T6a: response held for 5 cycles of rsp_ready low.
    run_txn(1'b0, F3_W, 32'h64, 32'h0, 5);
    check("t6_hold_rsp_cyc",  t_rsp_cyc,  2 + LAT);
    check("t6_hold_rdata",    t_rdata,    32'hDEAD_BEEF);
    check("t6_hold_unstable", t_unstable, 0);

    // T6b: reset while a load waits on the RAM.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h64;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_wait_rst_ready", bus.req_ready, 0);
    check("t6_wait_rst_valid", bus.rsp_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_wait_ready_after", bus.req_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.mem_en !== 1'b0) stale++;
    end
    check("t6_no_stale_rsp", stale, 0);

    // T6c: reset while a store is in ISSUE must not write RAM.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h70; bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6_issue_rst_en", bus.mem_en, 0);
    check("t6_issue_rst_we", bus.mem_we, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_issue_rst_ram",   ram[8'h1C], 32'h0);
    check("t6_issue_rst_ready", bus.req_ready, 1);
    run_txn(1'b0, F3_W, 32'h70, 32'h0, 0);
    check("t6_after_rsp_cyc", t_rsp_cyc, 2 + LAT);
    check("t6_after_rdata",   t_rdata,   32'h0);
    check("t6_after_err",     t_err,     0);

    check("be_zero_when_idle", be_leak, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
